// File: rtl/dbg_trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : dbg_trace_capture_if
// Purpose  : Control, trigger and readout signal bundle for dbg_trace_capture.
// Revision : 1.0
// ============================================================================
interface dbg_trace_capture_if #(
    parameter int PROBE_W = 32,
    parameter int ADDR_W  = 9
);
    logic               arm;
    logic               abort;
    logic [PROBE_W-1:0] probe;
    logic [PROBE_W-1:0] trig_mask;
    logic [PROBE_W-1:0] trig_value;
    logic               trig_edge;
    logic               busy;
    logic               triggered;
    logic               done;
    logic [ADDR_W-1:0]  trig_addr;
    logic [ADDR_W-1:0]  start_addr;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PROBE_W-1:0] rd_data;
    logic               rd_valid;

    modport master (
        output arm, abort, probe, trig_mask, trig_value, trig_edge, rd_en, rd_addr,
        input  busy, triggered, done, trig_addr, start_addr, rd_data, rd_valid
    );

    modport slave (
        input  arm, abort, probe, trig_mask, trig_value, trig_edge, rd_en, rd_addr,
        output busy, triggered, done, trig_addr, start_addr, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/dbg_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : dbg_trace_capture
// Purpose  : Circular trace buffer with masked-compare trigger and pre-trigger
//            window; captured samples are read back relative to the oldest one.
// Revision : 1.0
// ============================================================================
module dbg_trace_capture #(
    parameter int PROBE_W  = 32,
    parameter int DEPTH    = 512,
    parameter int ADDR_W   = 9,
    parameter int PRE_TRIG = 64
) (
    input wire clk,
    input wire reset,
    dbg_trace_capture_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_pre_trig  = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] c_pre_last  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] c_post_last = ADDR_W'(DEPTH - PRE_TRIG - 2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFILL   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_wptr;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_match_prev;
    logic               r_busy;
    logic               r_triggered;
    logic               r_done;
    logic [ADDR_W-1:0]  r_trig_addr;
    logic [ADDR_W-1:0]  r_start_addr;
    logic [PROBE_W-1:0] r_rd_data;
    logic               r_rd_valid;
    logic [PROBE_W-1:0] r_mem [DEPTH];

    logic               w_match;
    logic               w_fire;
    logic               w_wr_en;
    logic               w_rd_ok;
    logic [ADDR_W-1:0]  w_rd_phys;

    assign w_match   = ((bus.probe ^ bus.trig_value) & bus.trig_mask) == '0;
    assign w_fire    = bus.trig_edge ? (w_match & ~r_match_prev) : w_match;
    assign w_wr_en   = !bus.abort &&
                       (r_state == S_PREFILL || r_state == S_WAIT_TRIG || r_state == S_POST);
    assign w_rd_ok   = bus.rd_en && (r_state == S_DONE);
    assign w_rd_phys = r_start_addr + bus.rd_addr;

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= bus.probe;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_match_prev <= 1'b0;
            r_busy       <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            // The readout path is independent of the next state, so an abort
            // or re-arm right after a read still delivers it.
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= r_mem[w_rd_phys];
            end

            if (bus.abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_triggered <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.arm) begin
                            r_state      <= S_PREFILL;
                            r_wptr       <= '0;
                            r_cnt        <= '0;
                            r_match_prev <= 1'b0;
                            r_busy       <= 1'b1;
                            r_triggered  <= 1'b0;
                            r_done       <= 1'b0;
                        end
                    end
                    S_PREFILL: begin
                        r_wptr       <= r_wptr + 1'b1;
                        r_match_prev <= w_match;
                        if (r_cnt == c_pre_last) begin
                            r_cnt   <= '0;
                            r_state <= S_WAIT_TRIG;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WAIT_TRIG: begin
                        r_wptr       <= r_wptr + 1'b1;
                        r_match_prev <= w_match;
                        if (w_fire) begin
                            r_trig_addr  <= r_wptr;
                            r_start_addr <= r_wptr - c_pre_trig;
                            r_triggered  <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= S_POST;
                        end
                    end
                    S_POST: begin
                        r_wptr <= r_wptr + 1'b1;
                        if (r_cnt == c_post_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.triggered  = r_triggered;
    assign bus.done       = r_done;
    assign bus.trig_addr  = r_trig_addr;
    assign bus.start_addr = r_start_addr;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_dbg_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbg_trace_capture
// Purpose  : Directed captures with a read-data scoreboard for dbg_trace_capture.
// Revision : 1.0
// ============================================================================
module tb_dbg_trace_capture;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    dbg_trace_capture_if #(.PROBE_W(8), .ADDR_W(4)) bus ();

    dbg_trace_capture #(
        .PROBE_W (8),
        .DEPTH   (16),
        .ADDR_W  (4),
        .PRE_TRIG(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] log_mem [256];
    logic [7:0] last_rd = 8'h00;
    int         k = 0;
    int         cur_mode = 0;
    int         glitch_k = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-data monitor: each rd_valid must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got data %0h with no request outstanding", bus.rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", bus.rd_data, e.data);
                check("rd_latency", cyc - e.cyc, 1);
                last_rd = bus.rd_data;
            end
        end
    end

    function automatic logic [7:0] gen(input int mode, input int idx);
        logic [7:0] kb;
        kb = idx[7:0];
        if (mode == 1) return {kb[6:0], (idx == 7) ? 1'b0 : 1'b1};
        return kb;
    endfunction

    task automatic drive_sample();
        bus.probe = gen(cur_mode, k);
        log_mem[k[7:0]] = bus.probe;
    endtask

    task automatic arm_capture(input int mode, input logic [7:0] mask,
                               input logic [7:0] value, input logic edg);
        @(negedge clk);
        cur_mode       = mode;
        bus.trig_mask  = mask;
        bus.trig_value = value;
        bus.trig_edge  = edg;
        bus.rd_en      = 1'b0;
        bus.abort      = 1'b0;
        bus.arm        = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        k = 0;
        drive_sample();
        check("busy_after_arm", bus.busy, 1);
        check("done_after_arm", bus.done, 0);
    endtask

    task automatic step();
        @(negedge clk);
        k++;
        drive_sample();
        bus.arm = (k == glitch_k);
    endtask

    task automatic advance_to(input int last_written);
        int guard = 0;
        while (k - 1 < last_written && guard < 100) begin
            step();
            guard++;
        end
    endtask

    task automatic run_to_done(input int exp_trig);
        int trig_seen = -1;
        int guard = 0;
        while (!bus.done && guard < 100) begin
            if (bus.triggered && trig_seen < 0) trig_seen = k - 1;
            step();
            guard++;
        end
        bus.arm = 1'b0;
        check("done_seen", bus.done, 1);
        check("trig_sample", trig_seen, exp_trig);
        check("last_sample", k - 1, exp_trig + 11);
        check("trig_addr", bus.trig_addr, exp_trig % 16);
        check("start_addr", bus.start_addr, (exp_trig - 4) % 16);
        check("triggered", bus.triggered, 1);
        check("busy_done", bus.busy, 0);
    endtask

    task automatic read_all(input int exp_trig);
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            bus.rd_en   = 1'b1;
            bus.rd_addr = a[3:0];
            e.data = log_mem[exp_trig - 4 + a];
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        check("rd_drain", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_triggered"}, bus.triggered, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_trig_addr"}, bus.trig_addr, 0);
        check({tag, "_start_addr"}, bus.start_addr, 0);
        check({tag, "_rd_data"}, bus.rd_data, 0);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset          = 1'b1;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.probe      = '0;
        bus.trig_mask  = '0;
        bus.trig_value = '0;
        bus.trig_edge  = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Level trigger on an exact value.
        arm_capture(0, 8'hFF, 8'h20, 1'b0);
        run_to_done(32);
        read_all(32);

        // Low-nibble match first occurs in PREFILL and must be ignored.
        arm_capture(0, 8'h0F, 8'h02, 1'b0);
        run_to_done(18);
        read_all(18);

        // Edge mode on bit0: held high, dips at sample 7, rises at sample 8.
        arm_capture(1, 8'h01, 8'h01, 1'b1);
        run_to_done(8);
        read_all(8);

        // Same stimulus, level mode: fires on the first WAIT_TRIG sample.
        arm_capture(1, 8'h01, 8'h01, 1'b0);
        run_to_done(4);
        read_all(4);

        // Abort during POST, then a read that must be refused.
        arm_capture(0, 8'hFF, 8'h20, 1'b0);
        advance_to(35);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_triggered", bus.triggered, 0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd3;
        @(negedge clk);
        bus.rd_en = 1'b0;
        check("idle_rd_valid", bus.rd_valid, 0);
        check("idle_rd_hold", bus.rd_data, last_rd);

        // Arm pulsed mid-capture is ignored.
        glitch_k = 6;
        arm_capture(0, 8'hFF, 8'h20, 1'b0);
        run_to_done(32);
        glitch_k = -1;
        read_all(32);

        // Asynchronous reset between clock edges during WAIT_TRIG.
        arm_capture(0, 8'hFF, 8'h20, 1'b0);
        advance_to(6);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        arm_capture(0, 8'hFF, 8'h20, 1'b0);
        run_to_done(32);
        read_all(32);

        // Read then re-arm in the following cycle: the read still lands.
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd5;
        e.data = 8'h21;
        e.cyc  = cyc;
        exp_q.push_back(e);
        arm_capture(0, 8'h0F, 8'h02, 1'b0);
        run_to_done(18);
        read_all(18);

        // Arm and abort together from DONE: abort wins.
        @(negedge clk);
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        check("armabort_busy", bus.busy, 0);
        check("armabort_done", bus.done, 0);
        @(negedge clk);
        check("armabort_idle", bus.busy, 0);

        repeat (3) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
